// File: rtl/alu_muldiv_seq.sv
// Sequential multiply / divide / modulo unit for the execute stage.
// Radix-2 shift-add multiplier and restoring divider on magnitudes, sign fixup at the end.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int ALU_OP_LEN = 4,
  parameter logic [ALU_OP_LEN-1:0] ALU_OP_MUL = 4'hA,
  parameter logic [ALU_OP_LEN-1:0] ALU_OP_DIV = 4'hB,
  parameter logic [ALU_OP_LEN-1:0] ALU_OP_MOD = 4'hC,
  parameter logic ALU_UNSIGNED_EXT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ALU_OP_LEN-1:0] op,
  input  logic [WIDTH-1:0]      in1,
  input  logic [WIDTH-1:0]      in2,
  input  logic                  ext_mode,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      out,
  output logic [WIDTH-1:0]      out_hi,
  output logic                  zero,
  output logic                  neg,
  output logic                  div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic             is_mul_q, is_mod_q, neg_res_q, neg_rem_q, dz_q;
  logic [WIDTH-1:0] opb_q, acc_hi_q, acc_lo_q;
  logic             busy_q, done_q, zero_q, neg_q, div_zero_q;
  logic [WIDTH-1:0] out_q, out_hi_q;

  logic               is_signed_s, op_ok_s, a_neg_s, b_neg_s, div_ge_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, div_sub_s, quo_fix_s, rem_fix_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0]   hi_d, lo_d, out_d, out_hi_d;

  // Operand conditioning, one iteration step and the final sign fixup.
  always_comb begin
    is_signed_s = (ext_mode != ALU_UNSIGNED_EXT);
    op_ok_s     = (op == ALU_OP_MUL) || (op == ALU_OP_DIV) || (op == ALU_OP_MOD);
    a_neg_s     = is_signed_s & in1[WIDTH-1];
    b_neg_s     = is_signed_s & in2[WIDTH-1];
    mag_a_s     = a_neg_s ? -in1 : in1;
    mag_b_s     = b_neg_s ? -in2 : in2;

    mul_sum_s = {1'b0, acc_hi_q} + ({1'b0, opb_q} & {(WIDTH+1){acc_lo_q[0]}});
    // The shifted partial remainder is below 2*divisor, so a WIDTH-bit difference is exact.
    div_ge_s  = {acc_hi_q, acc_lo_q[WIDTH-1]} >= {1'b0, opb_q};
    div_sub_s = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]} - opb_q;

    if (is_mul_q) begin
      hi_d = mul_sum_s[WIDTH:1];
      lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
    end else if (div_ge_s) begin
      hi_d = div_sub_s;
      lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
      lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
    end

    prod_s     = {acc_hi_q, acc_lo_q};
    prod_fix_s = neg_res_q ? -prod_s : prod_s;
    quo_fix_s  = dz_q ? {WIDTH{1'b1}} : (neg_res_q ? -acc_lo_q : acc_lo_q);
    rem_fix_s  = neg_rem_q ? -acc_hi_q : acc_hi_q;

    if (is_mul_q) begin
      out_d    = prod_fix_s[WIDTH-1:0];
      out_hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
    end else if (is_mod_q) begin
      out_d    = rem_fix_s;
      out_hi_d = rem_fix_s;
    end else begin
      out_d    = quo_fix_s;
      out_hi_d = rem_fix_s;
    end
  end

  // Control FSM, datapath registers and registered result/flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      is_mul_q   <= 1'b0;
      is_mod_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      opb_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_q      <= '0;
      out_hi_q   <= '0;
      zero_q     <= 1'b1;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && op_ok_s && !flush) begin
            is_mul_q  <= (op == ALU_OP_MUL);
            is_mod_q  <= (op == ALU_OP_MOD);
            neg_res_q <= a_neg_s ^ b_neg_s;
            neg_rem_q <= a_neg_s;
            dz_q      <= (op != ALU_OP_MUL) && (in2 == '0);
            opb_q     <= (op == ALU_OP_MUL) ? mag_a_s : mag_b_s;
            acc_lo_q  <= (op == ALU_OP_MUL) ? mag_b_s : mag_a_s;
            acc_hi_q  <= '0;
            count_q   <= CNT_INIT;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_hi_q <= hi_d;
            acc_lo_q <= lo_d;
            count_q  <= count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            out_q      <= out_d;
            out_hi_q   <= out_hi_d;
            zero_q     <= (out_d == '0);
            neg_q      <= out_d[WIDTH-1];
            div_zero_q <= dz_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out      = out_q;
  assign out_hi   = out_hi_q;
  assign zero     = zero_q;
  assign neg      = neg_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: arithmetic/timing model checked every cycle
// plus literal expectations on selected results.
module tb_alu_muldiv_seq;

  localparam int W = 32;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_DIV = 4'hB;
  localparam logic [3:0] OP_MOD = 4'hC;
  localparam logic UNS = 1'b1;
  localparam logic SGN = 1'b0;

  logic clk = 1'b0;
  logic rst_n, start, ext_mode, flush;
  logic [3:0] op;
  logic [W-1:0] in1, in2;
  logic busy, done, zero, neg, div_zero;
  logic [W-1:0] out, out_hi;

  int n_vec = 0;
  int n_err = 0;
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
    .ext_mode(ext_mode), .flush(flush), .busy(busy), .done(done), .out(out),
    .out_hi(out_hi), .zero(zero), .neg(neg), .div_zero(div_zero)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic with 64-bit integers; truncating signed division.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ext, output logic [W-1:0] r_lo,
                                output logic [W-1:0] r_hi, output logic dz);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, p, q, r;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (o == OP_MUL) begin
      if (ext == UNS) p = ua * ub;
      else begin sq = sa * sb; p = sq; end
      r_lo = p[31:0];
      r_hi = p[63:32];
    end else begin
      if (b == '0) begin
        dz = 1'b1;
        q = 64'hFFFF_FFFF_FFFF_FFFF;
        r = ua;
      end else if (ext == UNS) begin
        q = ua / ub;
        r = ua % ub;
      end else begin
        sq = sa / sb;
        sr = sa % sb;
        q = sq;
        r = sr;
      end
      r_lo = (o == OP_MOD) ? r[31:0] : q[31:0];
      r_hi = r[31:0];
    end
  endfunction

  logic m_busy, m_done, m_dz, p_dz;
  int m_left;
  logic [W-1:0] m_out, m_hi, p_out, p_hi;

  // Transaction-level model: accepted request completes W+2 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      m_out = '0; m_hi = '0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (flush) begin
          m_busy = 1'b0;
          m_left = 0;
        end else begin
          m_left--;
          if (m_left == 1) begin
            m_out = p_out; m_hi = p_hi; m_dz = p_dz; m_done = 1'b1;
          end else if (m_left == 0) begin
            m_busy = 1'b0;
          end
        end
      end else if (start && !flush && (op == OP_MUL || op == OP_DIV || op == OP_MOD)) begin
        model(op, in1, in2, ext_mode, p_out, p_hi, p_dz);
        m_busy = 1'b1;
        m_left = W + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("out", out, m_out);
      check("out_hi", out_hi, m_hi);
      check("zero", {31'd0, zero}, {31'd0, (m_out == '0)});
      check("neg", {31'd0, neg}, {31'd0, m_out[W-1]});
      check("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
    end
  end

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ext);
    @(posedge clk);
    #1 start = 1'b1; op = o; in1 = a; in2 = b; ext_mode = ext;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int edges);
    edges = 0;
    for (int k = n0; k < n0 + 100; k++) begin
      @(negedge clk);
      if (done) begin
        edges = k;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ext);
    int e;
    issue(o, a, b, ext);
    wait_done(1, e);
    check({name, "_latency"}, W'(e), 32'd34);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int e;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 4'h0;
    in1 = '0; in2 = '0; ext_mode = SGN;
    repeat (2) @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_out", out, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("t1", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, UNS);
    check("t1_out", out, 32'h0000_0001);
    check("t1_hi", out_hi, 32'hFFFF_FFFE);

    run_op("t2", OP_MUL, 32'hFFFF_FFFD, 32'd7, SGN);
    check("t2_out", out, 32'hFFFF_FFEB);
    check("t2_hi", out_hi, 32'hFFFF_FFFF);
    check("t2_neg", {31'd0, neg}, 32'd1);

    run_op("t3_div", OP_DIV, 32'hFFFF_FFF9, 32'd2, SGN);
    check("t3_quo", out, 32'hFFFF_FFFD);
    check("t3_rem", out_hi, 32'hFFFF_FFFF);
    run_op("t3_mod", OP_MOD, 32'hFFFF_FFF9, 32'd2, SGN);
    check("t3_mod", out, 32'hFFFF_FFFF);
    run_op("t3_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, SGN);
    check("t3_ovf_quo", out, 32'h8000_0000);
    check("t3_ovf_rem", out_hi, 32'd0);
    check("t3_ovf_dz", {31'd0, div_zero}, 32'd0);
    run_op("t3_udiv", OP_DIV, 32'hFFFF_FFFF, 32'h10, UNS);
    check("t3_udiv_quo", out, 32'h0FFF_FFFF);
    check("t3_udiv_rem", out_hi, 32'h0000_000F);

    run_op("t4_dz", OP_DIV, 32'd100, 32'd0, SGN);
    check("t4_quo", out, 32'hFFFF_FFFF);
    check("t4_rem", out_hi, 32'd100);
    check("t4_dz", {31'd0, div_zero}, 32'd1);
    check("t4_zero", {31'd0, zero}, 32'd0);
    run_op("t4_ok", OP_DIV, 32'd6, 32'd3, SGN);
    check("t4_ok_quo", out, 32'd2);
    check("t4_ok_dz", {31'd0, div_zero}, 32'd0);

    run_op("mul_zero", OP_MUL, 32'h0001_0000, 32'h0001_0000, UNS);
    check("mul_zero_hi", out_hi, 32'd1);
    check("mul_zero_z", {31'd0, zero}, 32'd1);

    // unsupported op is not accepted
    @(posedge clk);
    #1 start = 1'b1; op = 4'h0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("badop_busy", {31'd0, busy}, 32'd0);

    // T5: start while busy is ignored; back-to-back accept after done
    issue(OP_MUL, 32'd5, 32'd6, UNS);
    repeat (8) @(posedge clk);
    #1 start = 1'b1; op = OP_DIV; in1 = 32'd1; in2 = 32'd1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(10, e);
    check("t5_latency", W'(e), 32'd34);
    check("t5_out", out, 32'd30);
    run_op("t5_b2b", OP_MUL, 32'd7, 32'd8, UNS);
    check("t5_b2b_out", out, 32'd56);

    // T6: flush at edge 5, then reset at edge 20 of another op
    issue(OP_MUL, 32'd9, 32'd9, UNS);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (40) @(negedge clk);
    check("t6_flush_busy", {31'd0, busy}, 32'd0);
    check("t6_flush_out", out, 32'd56);

    issue(OP_DIV, 32'd50, 32'd5, UNS);
    repeat (18) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_out", out, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t6_post_out", out, 32'd0);
    check("t6_post_zero", {31'd0, zero}, 32'd1);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
